mem_bus_responder: RTL

// - Memory-side end of the control unit's bus strobes (Address_Out / Bus_In / Bus_Out).
// - Latches the 16-bit address, then performs one 8-bit read or write to external memory.
// - Returns read data to the CPU data path and stalls the cycle counter while memory is busy.
// - Sits between the ControlUnit/register file and the memory map (ROM/WRAM/IO decode).

---
 rtl/mem_bus_responder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: memory-side end of the control unit's bus strobes.
// It latches a 16-bit address on i_Address_Out, then performs exactly one 8-bit
// read (i_Bus_In) or write (i_Bus_Out) against the memory map. The address is
// consumed by the access, so every transfer needs its own i_Address_Out.
//
// Optional build macro: MEM_WAIT_EN
//   defined   : i_Mem_Ready ends a transfer. If ready has not come after WAIT_MAX
//               stalled cycles, the transfer is aborted. An aborted read returns
//               OPEN_BUS, and any abort sets o_Protocol_Err.
//   undefined : fixed latency. Re/We is high for one cycle and the transfer
//               completes at the end of that cycle. o_Stall stays 0.
//
// Handshake semantics (all strobes are single-cycle and sampled on every rising edge):
//   - i_Address_Out, i_Bus_In and i_Bus_Out are requests without back-pressure.
//     A request that cannot be honoured is dropped and sets o_Protocol_Err.
//   - o_Mem_Re / o_Mem_We are one-cycle request pulses. o_Mem_Addr and
//     o_Mem_Wdata stay stable until the transfer completes.
//   - The memory completes a transfer by holding i_Mem_Ready high for one cycle
//     with i_Mem_Rdata valid. It may do so in the same cycle as Re/We.
//   - o_Stall is high in every pending cycle except the completing one, so the
//     cycle counter advances in the same cycle that data returns.
module mem_bus_responder #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 8,
  parameter int                WAIT_MAX = 15,
  parameter logic [DATA_W-1:0] OPEN_BUS = 8'hFF
) (
  input  logic              i_Clk,
  input  logic              i_Reset_n,
  input  logic              i_Address_Out,
  input  logic [ADDR_W-1:0] i_Address,
  input  logic              i_Bus_In,
  input  logic              i_Bus_Out,
  input  logic [DATA_W-1:0] i_Data_From_CPU,
  output logic [DATA_W-1:0] o_Data_To_CPU,
  output logic              o_Data_Valid,
  output logic              o_Write_Done,
  output logic              o_Stall,
  output logic              o_Protocol_Err,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [DATA_W-1:0] o_Mem_Wdata,
  output logic              o_Mem_Re,
  output logic              o_Mem_We,
  input  logic [DATA_W-1:0] i_Mem_Rdata,
  input  logic              i_Mem_Ready,
  output logic [1:0]        o_Dbg_State
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ADDR_VALID = 2'd1,
    RD_PEND    = 2'd2,
    WR_PEND    = 2'd3
  } state_t;

  state_t            state;
  // Address that arrived together with a bus strobe. It becomes current once
  // the transfer in flight completes.
  logic [ADDR_W-1:0] next_addr;
  logic              next_addr_v;
  logic              pending;
  logic              any_req;
  logic              done_now;
  logic              timed_out;

  assign pending     = (state == RD_PEND) || (state == WR_PEND);
  assign any_req     = i_Address_Out || i_Bus_In || i_Bus_Out;
  assign o_Dbg_State = state;

`ifdef MEM_WAIT_EN
  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Count the stalled cycles of the current transfer. The count is zero
  // whenever no transfer is pending.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      wait_cnt <= '0;
    end else if (pending && !done_now) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Real data takes priority over the timeout when both happen in one cycle.
  assign done_now  = i_Mem_Ready || (wait_cnt == CNT_W'(WAIT_MAX));
  assign timed_out = !i_Mem_Ready && (wait_cnt == CNT_W'(WAIT_MAX));
`else
  // Without wait states, memory always answers in the cycle it is asked.
  localparam int unused_wait_max = WAIT_MAX;
  logic unused_ready;
  assign unused_ready = i_Mem_Ready;
  assign done_now     = 1'b1;
  assign timed_out    = 1'b0;
`endif

  // Stall depends on i_Mem_Ready in the same cycle, so the completing cycle is
  // never stalled.
  assign o_Stall = pending && !done_now;

  // Main transfer FSM. Every output is registered, and the pulse outputs
  // default low on each edge.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state          <= IDLE;
      o_Mem_Addr     <= '0;
      o_Mem_Wdata    <= '0;
      o_Mem_Re       <= 1'b0;
      o_Mem_We       <= 1'b0;
      o_Data_To_CPU  <= '0;
      o_Data_Valid   <= 1'b0;
      o_Write_Done   <= 1'b0;
      o_Protocol_Err <= 1'b0;
      next_addr      <= '0;
      next_addr_v    <= 1'b0;
    end else begin
      o_Mem_Re     <= 1'b0;
      o_Mem_We     <= 1'b0;
      o_Data_Valid <= 1'b0;
      o_Write_Done <= 1'b0;
      case (state)
        IDLE: begin
          // A bus strobe with no address latched has nothing to act on.
          if (i_Bus_In || i_Bus_Out) o_Protocol_Err <= 1'b1;
          if (i_Address_Out) begin
            o_Mem_Addr <= i_Address;
            state      <= ADDR_VALID;
          end
        end
        ADDR_VALID: begin
          if (i_Bus_Out) begin
            // If both strobes arrive together, the write wins.
            if (i_Bus_In) o_Protocol_Err <= 1'b1;
            o_Mem_Wdata <= i_Data_From_CPU;
            o_Mem_We    <= 1'b1;
            state       <= WR_PEND;
          end else if (i_Bus_In) begin
            o_Mem_Re <= 1'b1;
            state    <= RD_PEND;
          end else if (i_Address_Out) begin
            o_Mem_Addr <= i_Address;
          end
          // An address that arrives with a strobe must not disturb the access
          // that is starting.
          if ((i_Bus_In || i_Bus_Out) && i_Address_Out) begin
            next_addr   <= i_Address;
            next_addr_v <= 1'b1;
          end
        end
        RD_PEND, WR_PEND: begin
          if (any_req) o_Protocol_Err <= 1'b1;
          if (done_now) begin
            if (state == RD_PEND) begin
              o_Data_To_CPU <= timed_out ? OPEN_BUS : i_Mem_Rdata;
              o_Data_Valid  <= 1'b1;
            end else begin
              o_Write_Done <= 1'b1;
            end
            if (timed_out) o_Protocol_Err <= 1'b1;
            if (next_addr_v) begin
              o_Mem_Addr  <= next_addr;
              next_addr_v <= 1'b0;
              state       <= ADDR_VALID;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
